muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside the ALU in the execute stage and drives hi/lo, which the ALU consumes for MFHI/MFLO results.
- Accepts an operation with a start pulse, iterates one bit per cycle, then signals done.
- The pipeline controller uses busy to stall dependent MFHI/MFLO reads.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
//   MULT/MULTU : shift-add, one multiplier bit per cycle, {hi,lo} = product
//   DIV/DIVU   : restoring shift-subtract, lo = quotient, hi = remainder
//   MTHI/MTLO  : single-edge load of hi or lo from a, busy stays low
// Ports:
//   clk, reset (async, active low)
//   start, op[2:0], a[n-1:0], b[n-1:0] : request (accepted only when !busy)
//   busy  : operation in flight (RUN or FIX)
//   done  : one-cycle pulse when hi/lo hold a new value
//   hi/lo : architectural HI/LO registers
// Optional macro MULDIV_EARLY_TERM_EN: multiplies leave RUN once the
// remaining multiplier bits are all zero.
module muldiv_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);
    localparam int CW = $clog2(n + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // acc: product accumulator, or {remainder, quotient/dividend} for divide
    logic [2*n-1:0] acc_q, acc_d;
    // mcand: left-shifting multiplicand, or divisor in the low half
    logic [2*n-1:0] mcand_q, mcand_d;
    // mplier: right-shifting multiplier, or raw dividend for divide-by-zero
    logic [n-1:0]   mplier_q, mplier_d;
    logic           div_q, div_d;
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic           bz_q, bz_d;
    logic           done_q, done_d;
    logic [n-1:0]   hi_q, hi_d;
    logic [n-1:0]   lo_q, lo_d;

    // Operand magnitudes for the signed ops (op[0]=0 means signed)
    logic           sa, sb;
    logic [n-1:0]   mag_a, mag_b;
    assign sa    = ~op[0] & a[n-1];
    assign sb    = ~op[0] & b[n-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Restoring divide step: shift the next dividend bit into the remainder
    logic [n:0]     shifted;
    logic [n:0]     trial;
    assign shifted = acc_q[2*n-1:n-1];
    assign trial   = shifted - {1'b0, mcand_q[n-1:0]};

    logic [2*n-1:0] prod_fix;
    logic [n-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[n-1:0] : acc_q[n-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];

    logic last;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        last      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d   = S_RUN;
                            cnt_d     = CW'(n);
                            div_d     = op[1];
                            neg_d     = sa ^ sb;
                            neg_rem_d = sa;
                            bz_d      = (b == '0);
                            if (op[1]) begin
                                acc_d    = {{n{1'b0}}, mag_a};
                                mcand_d  = {{n{1'b0}}, mag_b};
                                mplier_d = a;
                            end else begin
                                acc_d    = '0;
                                mcand_d  = {{n{1'b0}}, mag_a};
                                mplier_d = mag_b;
                            end
                        end
                        3'b100: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (div_q) begin
                    if (shifted >= {1'b0, mcand_q[n-1:0]})
                        acc_d = {trial[n-1:0], acc_q[n-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*n-2:0], 1'b0};
                end else begin
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = {mcand_q[2*n-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[n-1:1]};
                end
`ifdef MULDIV_EARLY_TERM_EN
                last = (cnt_q == CW'(1)) || (!div_q && (mplier_d == '0));
`else
                last = (cnt_q == CW'(1));
`endif
                if (last)
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bz_q) begin
                    lo_d = {n{1'b1}};
                    hi_d = mplier_q;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bz_q      <= bz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (n=32).
module tb_muldiv_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.n(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one arithmetic op, then check handshake, latency and result.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] hp, lp;
        int cyc;
        bit seen;
        @(negedge clk);
        hp = hi; lp = lo;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy0"}, {63'd0, busy}, 64'd1);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1;
            else if (cyc == 16) begin
                chk({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, hp});
                chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, lp});
                chk({tag, "_busy_mid"}, {63'd0, busy}, 64'd1);
            end
        end
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        // done after edge k+n+1
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int ndone;
        logic [31:0] hp;
        reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("multu_small", 3'b001, 32'h0001_0003, 32'h0000_0002, 32'h0, 32'h0002_0006);
        run_op("multu_max",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",    3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",     3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",        3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero",   3'b011, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_zero",    3'b010, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf",     3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // MTLO: single-edge load, hi untouched, no busy
        @(negedge clk);
        hp = hi;
        start = 1'b1; op = 3'b101; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_lo", {32'd0, lo}, 64'h0000_0000_DEAD_BEEF);
        chk("mtlo_hi", {32'd0, hi}, {32'd0, hp});
        chk("mtlo_done", {63'd0, done}, 64'd1);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("mtlo_done_pulse", {63'd0, done}, 64'd0);

        // MTHI
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mthi_hi", {32'd0, hi}, 64'h0000_0000_0BAD_F00D);
        chk("mthi_lo", {32'd0, lo}, 64'h0000_0000_DEAD_BEEF);

        // Reserved op: no done, no change
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = 32'h5555_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("rsvd_done", {63'd0, done}, 64'd0);
        chk("rsvd_busy", {63'd0, busy}, 64'd0);
        chk("rsvd_hi", {32'd0, hi}, 64'h0000_0000_0BAD_F00D);

        // Second start during RUN is ignored
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_hi", {32'd0, hi}, 64'd0);
        chk("busy_start_lo", {32'd0, lo}, 64'd15);

        // Reset mid-RUN aborts at once
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_run_busy", {63'd0, busy}, 64'd0);
        chk("rst_run_hi", {32'd0, hi}, 64'd0);
        chk("rst_run_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_run_nodone", {63'd0, done}, 64'd0);
        chk("rst_run_lo_after", {32'd0, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
